// File: rtl/fetch_stage.sv
// LC-3b instruction fetch stage with IF/ID latch: PC, imem read handshake,
// one-entry pending buffer for decode stalls, and branch redirect.
module fetch_stage #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_read,
    output logic [WIDTH-1:0] imem_address,
    input  logic             imem_resp,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             id_valid,
    output logic [WIDTH-1:0] id_ir,
    output logic [WIDTH-1:0] id_pc,
    output logic [3:0]       opcode,
    output logic             imm_check,
    output logic [1:0]       dbg_state
);

    // Handshake: imem_read is the request (valid) and is held, with imem_address
    // stable, until the one-cycle imem_resp strobe (ready) completes the transfer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PEND  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             id_valid_d;
    logic [WIDTH-1:0] id_ir_d, id_pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_ir_q, pend_ir_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic             slot_free;
    logic             consume;
    logic [WIDTH-1:0] addr_inc;
    logic [WIDTH-1:0] target;

    assign slot_free = !id_valid || !stall;
    assign consume   = id_valid && !stall;
    assign addr_inc  = addr_q + WIDTH'(2);
    assign target    = redirect_pc & ~WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            id_valid     <= 1'b0;
            id_ir        <= '0;
            id_pc        <= '0;
            pend_valid_q <= 1'b0;
            pend_ir_q    <= '0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            id_valid     <= id_valid_d;
            id_ir        <= id_ir_d;
            id_pc        <= id_pc_d;
            pend_valid_q <= pend_valid_d;
            pend_ir_q    <= pend_ir_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        id_valid_d   = id_valid;
        id_ir_d      = id_ir;
        id_pc_d      = id_pc;
        pend_valid_d = pend_valid_q;
        pend_ir_d    = pend_ir_q;
        pend_pc_d    = pend_pc_q;
        imem_read    = (state_q == FETCH) || (state_q == DROP);

        // An empty slot shows id_ir=0, which decodes as a no-op branch.
        if (consume) begin
            id_valid_d = 1'b0;
            id_ir_d    = '0;
        end

        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_resp) begin
                    pc_d   = addr_inc;
                    addr_d = addr_inc;
                    if (slot_free) begin
                        id_valid_d = 1'b1;
                        id_ir_d    = imem_rdata;
                        id_pc_d    = addr_inc;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_ir_d    = imem_rdata;
                        pend_pc_d    = addr_inc;
                        state_d      = PEND;
                    end
                end
            end
            PEND: begin
                if (!stall) begin
                    id_valid_d   = pend_valid_q;
                    id_ir_d      = pend_ir_q;
                    id_pc_d      = pend_pc_q;
                    pend_valid_d = 1'b0;
                    addr_d       = pc_q;
                    state_d      = FETCH;
                end
            end
            DROP: begin
                if (imem_resp) begin
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything above; an in-flight read must still
        // complete at its old address, so only DROP keeps addr_q.
        if (redirect) begin
            id_valid_d   = 1'b0;
            id_ir_d      = '0;
            pend_valid_d = 1'b0;
            pc_d         = target;
            if ((state_q == FETCH || state_q == DROP) && !imem_resp) begin
                addr_d  = addr_q;
                state_d = DROP;
            end else begin
                addr_d  = target;
                state_d = FETCH;
            end
        end
    end

    assign imem_address = addr_q;
    assign opcode       = id_ir[WIDTH-1 -: 4];
    assign imm_check    = id_ir[5];
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: responding memory model, expected-address
// model and an expected queue of {id_ir, id_pc} entries.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        id_valid;
  logic [15:0] id_ir;
  logic [15:0] id_pc;
  logic [3:0]  opcode;
  logic        imm_check;
  logic [1:0]  dbg_state;

  logic        b_imem_read;
  logic [15:0] b_imem_address;
  logic        b_id_valid;
  logic [15:0] b_id_ir;
  logic [15:0] b_id_pc;
  logic [3:0]  b_opcode;
  logic        b_imm_check;
  logic [1:0]  b_dbg_state;

  localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_PEND = 2'd2, S_DROP = 2'd3;

  fetch_stage #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ir(id_ir), .id_pc(id_pc),
    .opcode(opcode), .imm_check(imm_check), .dbg_state(dbg_state)
  );

  fetch_stage #(.WIDTH(16), .RESET_PC(16'hFFFE)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_read(b_imem_read), .imem_address(b_imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(b_id_valid), .id_ir(b_id_ir), .id_pc(b_id_pc),
    .opcode(b_opcode), .imm_check(b_imm_check), .dbg_state(b_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // scoreboard and model state
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [15:0] addr_log[$];
  logic [15:0] m_addr, m_pc;
  logic        dropping;
  logic        mem_hold;
  int          mem_lat;
  int          wait_cnt;
  logic        stall_v, redir_v;
  logic [15:0] rpc_v;
  logic        found;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'h1025;
    return {a[4:1] ^ 4'h6, a[11:0] ^ 12'hA5C};
  endfunction

  task automatic model_reset();
    m_addr   = 16'h0000;
    m_pc     = 16'h0000;
    dropping = 1'b0;
    wait_cnt = 0;
    exp_q.delete();
    addr_log.delete();
  endtask

  // Called just after a negedge: observe, drive this cycle's inputs, update model.
  task automatic apply();
    logic        rsp;
    logic [15:0] w;
    logic [31:0] e;
    rsp = imem_read && !mem_hold && (wait_cnt >= mem_lat);
    w   = rsp ? mem_word(m_addr) : 16'($urandom_range(0, 65535));
    imem_resp   = rsp;
    imem_rdata  = w;
    stall       = stall_v;
    redirect    = redir_v;
    redirect_pc = rpc_v;

    if (imem_read) check("imem_address", 32'(imem_address), 32'(m_addr));

    if (id_valid && !stall_v && !redir_v) begin
      check("sb_has_exp", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("id_ir", 32'(id_ir), 32'(e[31:16]));
        check("id_pc", 32'(id_pc), 32'(e[15:0]));
        check("opcode", 32'(opcode), 32'(e[31:28]));
        check("imm_check", 32'(imm_check), 32'(e[21]));
      end
    end

    if (redir_v) begin
      m_pc = rpc_v & 16'hFFFE;
      exp_q.delete();
      if (imem_read && !rsp) dropping = 1'b1;
      else begin
        m_addr   = m_pc;
        dropping = 1'b0;
      end
    end else if (rsp) begin
      if (dropping) begin
        m_addr   = m_pc;
        dropping = 1'b0;
      end else begin
        exp_q.push_back({w, m_addr + 16'd2});
        m_addr = m_addr + 16'd2;
        m_pc   = m_addr;
      end
    end

    if (rsp) addr_log.push_back(imem_address);
    if (rsp) wait_cnt = 0;
    else if (imem_read) wait_cnt++;
    else wait_cnt = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      apply();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    stall_v = 1'b0; redir_v = 1'b0; rpc_v = '0; mem_hold = 1'b0; mem_lat = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_ir", 32'(id_ir), 32'd0);
    check("rst_id_pc", 32'(id_pc), 32'd0);
    check("rst_imem_read", 32'(imem_read), 32'd0);
    check("rst_address", 32'(imem_address), 32'h0000);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_b_address", 32'(b_imem_address), 32'hFFFE);
    rst_n = 1'b1;
  endtask

  // stimulus
  initial begin
    rst_n = 1'b0;
    do_reset();

    // 1: one-cycle memory latency, sequential fetch; dut_b wraps from FFFE
    mem_lat = 1;
    @(negedge clk);
    check("t1_read", 32'(imem_read), 32'd1);
    check("t5_b_first_addr", 32'(b_imem_address), 32'hFFFE);
    apply();
    @(negedge clk); apply();
    @(negedge clk);
    check("t1_id_pc", 32'(id_pc), 32'h0002);
    check("t1_opcode", 32'(opcode), 32'h6);
    check("t5_b_id_valid", 32'(b_id_valid), 32'd1);
    check("t5_b_id_pc", 32'(b_id_pc), 32'h0000);
    check("t5_b_id_ir", 32'({b_opcode, b_imm_check, b_id_ir}), {4'h6, 1'b0, 16'h6A5C, 11'h0} >> 11);
    check("t5_b_second_addr", 32'(b_imem_address), 32'h0000);
    check("t5_b_state", 32'({b_imem_read, b_dbg_state}), 32'({1'b1, S_FETCH}));
    apply();
    cycles(5);
    for (int i = 0; i < 3; i++)
      check("t1_addr", (addr_log.size() > i) ? 32'(addr_log[i]) : 32'hFFFF_FFFF, 32'(2 * i));

    // 2: stall holds ADD-imm word while the next response goes to the pending buffer
    mem_lat = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (id_valid && id_ir == 16'h1025) begin
        found = 1'b1;
        break;
      end
      apply();
    end
    check("t2_found", 32'(found), 32'd1);
    stall_v = 1'b1;
    apply();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t2_hold_ir", 32'(id_ir), 32'h1025);
      check("t2_opcode", 32'(opcode), 32'h1);
      check("t2_imm_check", 32'(imm_check), 32'd1);
      check("t2_read_low", 32'(imem_read), 32'd0);
      check("t2_state", 32'(dbg_state), 32'(S_PEND));
      apply();
    end
    stall_v = 1'b0;
    @(negedge clk);
    check("t2_still_pend", 32'(dbg_state), 32'(S_PEND));
    apply();
    @(negedge clk);
    check("t2_next_valid", 32'(id_valid), 32'd1);
    check("t2_next_pc", 32'(id_pc), 32'h0014);
    apply();

    // 3: redirect during an outstanding read without response
    mem_hold = 1'b1;
    cycles(1);
    @(negedge clk);
    check("t3_read", 32'(imem_read), 32'd1);
    redir_v = 1'b1; rpc_v = 16'h0041;
    apply();
    redir_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t3_state", 32'(dbg_state), 32'(S_DROP));
      check("t3_id_valid", 32'(id_valid), 32'd0);
      check("t3_read", 32'(imem_read), 32'd1);
      apply();
    end
    mem_hold = 1'b0;
    @(negedge clk);
    apply();
    @(negedge clk);
    check("t3_new_addr", 32'(imem_address), 32'h0040);
    check("t3_id_valid_after", 32'(id_valid), 32'd0);
    apply();

    // 4: redirect in the same cycle as a response
    @(negedge clk);
    check("t4_read", 32'(imem_read), 32'd1);
    redir_v = 1'b1; rpc_v = 16'h0100;
    apply();
    redir_v = 1'b0;
    @(negedge clk);
    check("t4_addr", 32'(imem_address), 32'h0100);
    check("t4_id_valid", 32'(id_valid), 32'd0);
    check("t4_id_ir", 32'(id_ir), 32'h0000);
    apply();
    cycles(3);

    // random stalls, latencies and occasional redirects
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      stall_v = 1'($urandom_range(0, 1));
      mem_lat = $urandom_range(0, 2);
      redir_v = ($urandom_range(0, 11) == 0);
      rpc_v   = 16'($urandom_range(0, 65535));
      apply();
    end
    stall_v = 1'b0; redir_v = 1'b0; mem_hold = 1'b1;
    cycles(4);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // 6: reset asserted mid-request
    mem_hold = 1'b0; mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id_valid && imem_read) begin
        found = 1'b1;
        break;
      end
      apply();
    end
    check("t6_found", 32'(found), 32'd1);
    rst_n = 1'b0;
    imem_resp = 1'b0;
    #1;
    check("t6_id_valid", 32'(id_valid), 32'd0);
    check("t6_read", 32'(imem_read), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(S_IDLE));
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_restart_read", 32'(imem_read), 32'd1);
    check("t6_restart_addr", 32'(imem_address), 32'h0000);
    apply();
    cycles(6);
    mem_hold = 1'b1;
    cycles(4);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
